// File: rtl/y86_alu_pkg.sv
// Shared constants, state encoding and condition helpers for the Y-86 execute-stage ALU sequencer.
package y86_alu_pkg;
  localparam int W_DFLT = 64;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_XOR = 4'd3;

  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  function automatic logic fn_legal(input logic [3:0] fn);
    return fn <= FN_XOR;
  endfunction

  function automatic logic cond_legal(input logic [3:0] c);
    return c <= C_G;
  endfunction

  // Illegal codes evaluate to 0 so the caller needs no extra masking.
  function automatic logic cond_eval(input logic [3:0] c, input cc_t cc);
    logic s;
    logic res;
    s = cc.sf ^ cc.of;
    case (c)
      C_ALWAYS: res = 1'b1;
      C_LE:     res = s | cc.zf;
      C_L:      res = s;
      C_E:      res = cc.zf;
      C_NE:     res = ~cc.zf;
      C_GE:     res = ~s;
      C_G:      res = ~s & ~cc.zf;
      default:  res = 1'b0;
    endcase
    return res;
  endfunction
endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle between decode, the ALU sequencer and the memory stage.
interface alu_sequencer_if #(parameter int W = 64);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_fn;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_set_cc;
  logic [3:0]   in_cond;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_cnd;
  logic         out_err;
  logic         cc_zf;
  logic         cc_sf;
  logic         cc_of;

  modport master (
    output in_valid, in_fn, in_a, in_b, in_set_cc, in_cond, out_ready,
    input  in_ready, out_valid, out_result, out_cnd, out_err, cc_zf, cc_sf, cc_of
  );

  modport slave (
    input  in_valid, in_fn, in_a, in_b, in_set_cc, in_cond, out_ready,
    output in_ready, out_valid, out_result, out_cnd, out_err, cc_zf, cc_sf, cc_of
  );
endinterface

// File: rtl/alu64_core.sv
// Combinational add/sub/and/xor unit with ZF/SF/OF; illegal fn yields r=0 and no overflow.
module alu64_core import y86_alu_pkg::*; #(
  parameter int W = W_DFLT
) (
  input  logic [3:0]   i_fn,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_r,
  output logic         o_zf,
  output logic         o_sf,
  output logic         o_of
);
  logic [W-1:0] w_sum;
  logic [W-1:0] w_dif;

  // Y-86 operand order: valB op valA.
  assign w_sum = i_b + i_a;
  assign w_dif = i_b - i_a;

  always_comb begin
    o_r  = '0;
    o_of = 1'b0;
    case (i_fn)
      FN_ADD: begin
        o_r  = w_sum;
        o_of = (i_a[W-1] == i_b[W-1]) & (w_sum[W-1] != i_a[W-1]);
      end
      FN_SUB: begin
        o_r  = w_dif;
        o_of = (i_a[W-1] != i_b[W-1]) & (w_dif[W-1] != i_b[W-1]);
      end
      FN_AND:  o_r = i_b & i_a;
      FN_XOR:  o_r = i_b ^ i_a;
      default: o_r = '0;
    endcase
  end

  assign o_zf = (o_r == '0);
  assign o_sf = o_r[W-1];
endmodule

// File: rtl/alu_sequencer.sv
// Execute-stage sequencer: IDLE/EXEC/DONE handshake FSM, operand/result registers, CC register, cond evaluator.
module alu_sequencer import y86_alu_pkg::*; #(
  parameter int         W        = W_DFLT,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input logic            clk,
  input logic            rst_n,
  alu_sequencer_if.slave bus
);
  state_t       r_state, w_next;
  logic [3:0]   r_fn, r_cond;
  logic [W-1:0] r_a, r_b, r_result;
  logic         r_set_cc, r_cnd, r_err;
  cc_t          r_cc;

  logic         w_in_ready, w_accept, w_fn_ok, w_cond_ok;
  logic [W-1:0] w_r;
  logic         w_zf, w_sf, w_of;

  alu64_core #(.W(W)) u_core (
    .i_fn (r_fn),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_r  (w_r),
    .o_zf (w_zf),
    .o_sf (w_sf),
    .o_of (w_of)
  );

  // Gated by rst_n so in_ready reads 0 for the whole reset window.
  assign w_in_ready = rst_n & ((r_state == S_IDLE) | ((r_state == S_DONE) & bus.out_ready));
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_fn_ok    = fn_legal(r_fn);
  assign w_cond_ok  = cond_legal(r_cond);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_EXEC;
      S_EXEC:  w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = bus.in_valid ? S_EXEC : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fn     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_set_cc <= 1'b0;
      r_cond   <= '0;
      r_result <= '0;
      r_cnd    <= 1'b0;
      r_err    <= 1'b0;
      r_cc     <= cc_t'(CC_RESET);
    end else begin
      if (w_accept) begin
        r_fn     <= bus.in_fn;
        r_a      <= bus.in_a;
        r_b      <= bus.in_b;
        r_set_cc <= bus.in_set_cc;
        r_cond   <= bus.in_cond;
      end
      // Condition sees the CC as it stood before this op's own update.
      if (r_state == S_EXEC) begin
        r_result <= w_fn_ok ? w_r : '0;
        r_cnd    <= cond_eval(r_cond, r_cc);
        r_err    <= ~w_fn_ok | ~w_cond_ok;
        if (r_set_cc & w_fn_ok) r_cc <= cc_t'({w_zf, w_sf, w_of});
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = (r_state == S_DONE);
  assign bus.out_result = r_result;
  assign bus.out_cnd    = r_cnd;
  assign bus.out_err    = r_err;
  assign bus.cc_zf      = r_cc.zf;
  assign bus.cc_sf      = r_cc.sf;
  assign bus.cc_of      = r_cc.of;
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench: driver predicts each accepted op with a signed-arithmetic model; monitor checks on handshake.
module tb_alu_sequencer;
  localparam int W = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_sequencer_if #(.W(W)) bus();

  alu_sequencer #(.W(W), .CC_RESET(3'b100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] r;
    logic        cnd;
    logic        err;
    logic [2:0]  cc;
    int          acc;
  } exp_t;

  exp_t       q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [2:0] m_cc     = 3'b100;
  bit         rnd_mode = 1'b0;
  logic       prev_v   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model: overflow from 65-bit sign-extended arithmetic, cond from the table.
  task automatic predict(input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b,
                         input logic set, input logic [3:0] cond, output exp_t e);
    logic [64:0] ext;
    logic [63:0] r;
    logic        of, s, pz;
    ext = '0;
    r   = '0;
    of  = 1'b0;
    case (fn)
      4'd0: begin ext = {b[63], b} + {a[63], a}; r = ext[63:0]; of = ext[64] ^ ext[63]; end
      4'd1: begin ext = {b[63], b} - {a[63], a}; r = ext[63:0]; of = ext[64] ^ ext[63]; end
      4'd2: r = b & a;
      4'd3: r = b ^ a;
      default: r = '0;
    endcase
    pz = m_cc[2];
    s  = m_cc[1] ^ m_cc[0];
    case (cond)
      4'd0: e.cnd = 1'b1;
      4'd1: e.cnd = s | pz;
      4'd2: e.cnd = s;
      4'd3: e.cnd = pz;
      4'd4: e.cnd = !pz;
      4'd5: e.cnd = !s;
      4'd6: e.cnd = !s && !pz;
      default: e.cnd = 1'b0;
    endcase
    e.r   = r;
    e.err = (fn > 4'd3) || (cond > 4'd6);
    if (fn <= 4'd3 && set) m_cc = {(r == 64'd0), r[63], of};
    e.cc  = m_cc;
    e.acc = 0;
  endtask

  task automatic send(input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b,
                      input logic set, input logic [3:0] cond, input bit raise_ready,
                      output int waited);
    exp_t e;
    bit   done;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b1;
    bus.in_fn     = fn;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_set_cc = set;
    bus.in_cond   = cond;
    if (raise_ready) bus.out_ready = 1'b1;
    waited = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        predict(fn, a, b, set, cond, e);
        e.acc = cyc + 1;
        q.push_back(e);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 50) begin
          fail("accept_timeout");
          done = 1'b1;
        end else begin
          @(posedge clk);
          #1;
          if (rnd_mode) bus.out_ready = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    // Junk on the request bus while not valid must be ignored.
    bus.in_valid  = 1'b0;
    bus.in_fn     = 4'($urandom);
    bus.in_a      = {$urandom, $urandom};
    bus.in_b      = {$urandom, $urandom};
    bus.in_set_cc = 1'($urandom);
    bus.in_cond   = 4'($urandom);
    if (rnd_mode) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) fail("drain_timeout");
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Monitor: latency on each rising out_valid, full compare on each output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v <= 1'b0;
    end else begin
      if (bus.out_valid && !prev_v) begin
        if (q.size() == 0) fail("unexpected_valid");
        else chk("latency", 64'(cyc - q[0].acc), 64'd1);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          fail("unexpected_output");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", bus.out_result, e.r);
          chk("cnd", 64'(bus.out_cnd), 64'(e.cnd));
          chk("err", 64'(bus.out_err), 64'(e.err));
          chk("cc", 64'({bus.cc_zf, bus.cc_sf, bus.cc_of}), 64'(e.cc));
        end
      end
      prev_v <= bus.out_valid;
    end
  end

  initial begin
    int          w;
    logic [63:0] held;
    logic [3:0]  fn;
    bus.in_valid  = 1'b0;
    bus.in_fn     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_set_cc = 1'b0;
    bus.in_cond   = '0;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", bus.out_result, 64'd0);
    chk("rst_cnd_err", 64'({bus.out_cnd, bus.out_err}), 64'd0);
    chk("rst_cc", 64'({bus.cc_zf, bus.cc_sf, bus.cc_of}), 64'b100);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

    send(4'd2, 64'd1, 64'd5, 1'b1, 4'd0, 1'b0, w);
    send(4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 4'd0, 1'b0, w);
    send(4'd2, 64'd0, 64'd0, 1'b0, 4'd2, 1'b0, w);
    send(4'd2, 64'd0, 64'd0, 1'b0, 4'd1, 1'b0, w);
    send(4'd1, 64'd5, 64'd5, 1'b1, 4'd3, 1'b0, w);
    send(4'd2, 64'd0, 64'd0, 1'b0, 4'd3, 1'b0, w);
    send(4'd7, 64'd3, 64'd4, 1'b1, 4'd0, 1'b0, w);
    send(4'd0, 64'd1, 64'd2, 1'b0, 4'd9, 1'b0, w);
    wait_drain();

    // Backpressure, then back-to-back accept with out_ready raised alongside in_valid.
    bus.out_ready = 1'b0;
    send(4'd3, 64'hF0F0, 64'h0FF0, 1'b1, 4'd4, 1'b0, w);
    w = 0;
    while (!bus.out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.out_valid) fail("bp_valid_timeout");
    held = bus.out_result;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_stable", bus.out_result, held);
    end
    send(4'd0, 64'd1, 64'd1, 1'b1, 4'd0, 1'b1, w);
    chk("b2b_accept_wait", 64'(w), 64'd0);
    wait_drain();

    // Reset while the add is in EXEC: no CC write, outputs back to reset values at once.
    send(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'd0, 1'b0, w);
    rst_n = 1'b0;
    #1;
    q.delete();
    m_cc = 3'b100;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_result", bus.out_result, 64'd0);
    chk("mid_rst_cc", 64'({bus.cc_zf, bus.cc_sf, bus.cc_of}), 64'b100);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(4'd1, 64'd2, 64'd9, 1'b1, 4'd6, 1'b0, w);
    wait_drain();

    rnd_mode = 1'b1;
    for (int k = 0; k < 150; k++) begin
      fn = ($urandom_range(0, 9) > 8) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      send(fn, pick_operand(), pick_operand(), 1'($urandom), 4'($urandom_range(0, 8)), 1'b0, w);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rnd_mode = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_drain();
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "timeout");
  end
endmodule
